ysyx_24110026_wb_arbiter: RTL and testbench

YSYX_24110026_WB_ARBITER -- requirements
Module: ysyx_24110026_wb_arbiter

---
 rtl/ysyx_24110026_wb_arbiter.sv | 142 ++++++++++++++
 tb/tb_ysyx_24110026_wb_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24110026_wb_arbiter.sv
// ysyx_24110026_wb_arbiter
//
// Writeback arbiter between the EXU and LSU result paths. It drives a single
// registered regfile write port, keeps a scoreboard of registers with an
// outstanding load, and reports read-after-write hazards for two source regs.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   exu_valid/ready/waddr/wdata     EXU writeback request (valid/ready)
//   lsu_valid/ready/waddr/wdata     LSU writeback request (valid/ready)
//   rf_wen/rf_waddr/rf_wdata        registered regfile write port (1-cycle latency)
//   sb_set_valid/ready/addr         marks the rd of an issued load as busy
//   rs1_addr, rs2_addr, hazard      combinational hazard query
//
// Configuration:
//   YSYX_24110026_WBARB_RR_EN  defined   -> round-robin on conflict
//                              undefined -> LSU always wins a conflict
module ysyx_24110026_wb_arbiter (
    input  logic        clk,
    input  logic        rst,

    input  logic        exu_valid,
    output logic        exu_ready,
    input  logic [4:0]  exu_waddr,
    input  logic [31:0] exu_wdata,

    input  logic        lsu_valid,
    output logic        lsu_ready,
    input  logic [4:0]  lsu_waddr,
    input  logic [31:0] lsu_wdata,

    output logic        rf_wen,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,

    input  logic        sb_set_valid,
    output logic        sb_set_ready,
    input  logic [4:0]  sb_set_addr,

    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic        hazard
);

    logic [31:1] busy_q;
    logic [31:0] busy_vec;
    logic [31:0] busy_next;
    logic        exu_grant;
    logic        lsu_grant;
    logic        lsu_wins;
    logic        sb_set_fire;
    logic        rs1_hazard;
    logic        rs2_hazard;

    // x0 is hard-wired as never busy so the vector can be indexed by any address.
    assign busy_vec = {busy_q, 1'b0};

`ifdef YSYX_24110026_WBARB_RR_EN
    // Remembers whether the most recent grant went to the LSU. Reset to
    // "last was EXU" so the LSU wins the first conflict after reset.
    logic last_lsu_q;

    assign lsu_wins = !last_lsu_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_lsu_q <= 1'b0;
        end else if (exu_grant || lsu_grant) begin
            last_lsu_q <= lsu_grant;
        end
    end
`else
    assign lsu_wins = 1'b1;
`endif

    // Each requester is ready unless the other one is also valid and holds
    // priority; at most one grant can therefore happen per cycle.
    always_comb begin
        exu_ready = !(lsu_valid && lsu_wins);
        lsu_ready = !(exu_valid && !lsu_wins);
    end

    assign exu_grant   = exu_valid && exu_ready;
    assign lsu_grant   = lsu_valid && lsu_ready;

    assign sb_set_ready = !busy_vec[sb_set_addr];
    assign sb_set_fire  = sb_set_valid && sb_set_ready && (sb_set_addr != 5'd0);

    // Registered regfile write. The address/data follow the granted requester;
    // a write to x0 still handshakes but never raises rf_wen.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wen   <= 1'b0;
            rf_waddr <= 5'd0;
            rf_wdata <= 32'd0;
        end else begin
            rf_wen <= (exu_grant && (exu_waddr != 5'd0)) ||
                      (lsu_grant && (lsu_waddr != 5'd0));
            if (lsu_grant) begin
                rf_waddr <= lsu_waddr;
                rf_wdata <= lsu_wdata;
            end else if (exu_grant) begin
                rf_waddr <= exu_waddr;
                rf_wdata <= exu_wdata;
            end
        end
    end

    // Scoreboard next state: LSU writeback clears, load issue sets. The set is
    // applied after the clear so a same-cycle set/clear on one register keeps
    // the register busy (the newer load still owns it).
    always_comb begin
        busy_next = busy_vec;
        if (lsu_grant && (lsu_waddr != 5'd0)) begin
            busy_next[lsu_waddr] = 1'b0;
        end
        if (sb_set_fire) begin
            busy_next[sb_set_addr] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 31'd0;
        end else begin
            busy_q <= busy_next[31:1];
        end
    end

    // A source register is hazardous while its load is outstanding, and also
    // for the one cycle in which its writeback sits in the rf output register
    // and is not yet visible in the regfile.
    always_comb begin
        rs1_hazard = (rs1_addr != 5'd0) &&
                     (busy_vec[rs1_addr] || (rf_wen && (rf_waddr == rs1_addr)));
        rs2_hazard = (rs2_addr != 5'd0) &&
                     (busy_vec[rs2_addr] || (rf_wen && (rf_waddr == rs2_addr)));
        hazard     = rs1_hazard || rs2_hazard;
    end

endmodule

// File: tb/tb_ysyx_24110026_wb_arbiter.sv
// tb_ysyx_24110026_wb_arbiter
//
// Directed self-checking bench for ysyx_24110026_wb_arbiter. Inputs change one
// time unit after a rising edge; combinational outputs are checked after they
// settle, registered outputs one time unit after the following rising edge.
module tb_ysyx_24110026_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        exu_valid;
    logic        exu_ready;
    logic [4:0]  exu_waddr;
    logic [31:0] exu_wdata;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_waddr;
    logic [31:0] lsu_wdata;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        sb_set_valid;
    logic        sb_set_ready;
    logic [4:0]  sb_set_addr;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        hazard;

    int total;
    int bad;

    ysyx_24110026_wb_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .exu_valid    (exu_valid),
        .exu_ready    (exu_ready),
        .exu_waddr    (exu_waddr),
        .exu_wdata    (exu_wdata),
        .lsu_valid    (lsu_valid),
        .lsu_ready    (lsu_ready),
        .lsu_waddr    (lsu_waddr),
        .lsu_wdata    (lsu_wdata),
        .rf_wen       (rf_wen),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .sb_set_valid (sb_set_valid),
        .sb_set_ready (sb_set_ready),
        .sb_set_addr  (sb_set_addr),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .hazard       (hazard)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic ev, input logic [4:0] ea, input logic [31:0] ed,
                                 input logic lv, input logic [4:0] la, input logic [31:0] ld,
                                 input logic sv, input logic [4:0] sa,
                                 input logic [4:0] r1, input logic [4:0] r2);
        exu_valid    = ev;
        exu_waddr    = ea;
        exu_wdata    = ed;
        lsu_valid    = lv;
        lsu_waddr    = la;
        lsu_wdata    = ld;
        sb_set_valid = sv;
        sb_set_addr  = sa;
        rs1_addr     = r1;
        rs2_addr     = r2;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected conflict winners for three back-to-back conflicts (1 = LSU).
    logic [2:0] lsuWinSeq;

    initial begin
        total = 0;
        bad   = 0;
`ifdef YSYX_24110026_WBARB_RR_EN
        lsuWinSeq = 3'b101;
`else
        lsuWinSeq = 3'b111;
`endif
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();

        // Reset state
        checkOutput("rst_rf_wen",   32'(rf_wen),   32'd0);
        checkOutput("rst_rf_waddr", 32'(rf_waddr), 32'd0);
        checkOutput("rst_rf_wdata", rf_wdata,      32'd0);
        checkOutput("rst_hazard",   32'(hazard),   32'd0);
        checkOutput("rst_sb_ready", 32'(sb_set_ready), 32'd1);
        rst = 1'b0;

        // Lone EXU write to x5
        applyStimulus(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("exu_lone_ready", 32'(exu_ready), 32'd1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("exu_lone_wen",   32'(rf_wen),   32'd1);
        checkOutput("exu_lone_waddr", 32'(rf_waddr), 32'd5);
        checkOutput("exu_lone_wdata", rf_wdata,      32'hDEADBEEF);
        tick();
        checkOutput("exu_lone_wen_off", 32'(rf_wen), 32'd0);

        // Three-cycle conflict, EXU x3 vs LSU x4
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 3, 32'h33, 1, 4, 32'h44, 0, 0, 0, 0);
            checkOutput($sformatf("conf%0d_lsu_ready", i), 32'(lsu_ready), 32'(lsuWinSeq[2-i]));
            checkOutput($sformatf("conf%0d_exu_ready", i), 32'(exu_ready), 32'(!lsuWinSeq[2-i]));
            tick();
            checkOutput($sformatf("conf%0d_waddr", i), 32'(rf_waddr),
                        lsuWinSeq[2-i] ? 32'd4 : 32'd3);
            checkOutput($sformatf("conf%0d_wen", i), 32'(rf_wen), 32'd1);
        end

        // Scoreboard cycle on x7
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 7, 0, 0);
        checkOutput("sb7_set_ready", 32'(sb_set_ready), 32'd1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
        checkOutput("sb7_hazard_busy", 32'(hazard), 32'd1);
        checkOutput("sb7_reset_blocked", 32'(sb_set_ready), 32'd0);
        tick();
        applyStimulus(0, 0, 0, 1, 7, 32'h77, 0, 0, 7, 0);
        checkOutput("sb7_lsu_ready", 32'(lsu_ready), 32'd1);
        checkOutput("sb7_hazard_wb", 32'(hazard), 32'd1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
        checkOutput("sb7_hazard_pending", 32'(hazard), 32'd1);
        checkOutput("sb7_wdata", rf_wdata, 32'h77);
        tick();
        checkOutput("sb7_hazard_clear", 32'(hazard), 32'd0);

        // x0 handling
        applyStimulus(1, 0, 32'h1234, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("x0_exu_ready", 32'(exu_ready), 32'd1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        checkOutput("x0_rf_wen", 32'(rf_wen), 32'd0);
        checkOutput("x0_sb_ready", 32'(sb_set_ready), 32'd1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        checkOutput("x0_sb_ready_after", 32'(sb_set_ready), 32'd1);
        checkOutput("x0_hazard", 32'(hazard), 32'd0);

        // Same-cycle set and LSU clear on x9
        applyStimulus(0, 0, 0, 1, 9, 32'h99, 1, 9, 0, 9);
        checkOutput("x9_sb_ready", 32'(sb_set_ready), 32'd1);
        checkOutput("x9_lsu_ready", 32'(lsu_ready), 32'd1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 9);
        checkOutput("x9_hazard_n1", 32'(hazard), 32'd1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 9, 0, 9);
        checkOutput("x9_hazard_busy", 32'(hazard), 32'd1);
        checkOutput("x9_still_busy", 32'(sb_set_ready), 32'd0);

        // Reset mid-operation: busy x3 plus a pending LSU write
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 3, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 1, 12, 32'hAB, 0, 0, 3, 0);
        checkOutput("mid_hazard_x3", 32'(hazard), 32'd1);
        tick();
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 3, 0);
        tick();
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 3, 0);
        checkOutput("mid_rf_wen", 32'(rf_wen), 32'd0);
        checkOutput("mid_rf_waddr", 32'(rf_waddr), 32'd0);
        checkOutput("mid_hazard", 32'(hazard), 32'd0);
        applyStimulus(1, 3, 32'h33, 1, 4, 32'h44, 0, 0, 0, 0);
        checkOutput("mid_conf_lsu_ready", 32'(lsu_ready), 32'd1);
        checkOutput("mid_conf_exu_ready", 32'(exu_ready), 32'd0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("mid_conf_waddr", 32'(rf_waddr), 32'd4);
        checkOutput("mid_conf_wdata", rf_wdata, 32'h44);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
